// File: rtl/weight_word_unpacker_pkg.sv
// rtl/weight_word_unpacker_pkg.sv - shared constants, state type and clog2 for the weight unpacker
package weight_word_unpacker_pkg;

  localparam int K_SIZE  = 3;
  localparam int CI1     = 1;
  localparam int CO1     = 4;
  localparam int CI2     = 4;
  localparam int CO2     = 8;
  localparam int I_SIZE3 = 362;
  localparam int CO3     = 8;

  // Total weight count: conv1 + conv2 kernels plus the FC matrix.
  localparam int W_SIZE = K_SIZE * K_SIZE * CI1 * CO1
                        + K_SIZE * K_SIZE * CI2 * CO2
                        + I_SIZE3 * CO3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } unpack_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// rtl/sync_word_fifo.sv - show-ahead word FIFO with registered full/empty and async + sync clear
module sync_word_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          do_push, do_pop;

  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata     = mem[rd_ptr];

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/weight_word_unpacker.sv
// rtl/weight_word_unpacker.sv - unpacks 32-bit weight words into a BW-bit write stream
// Optional WUNPACK_CHECKSUM_EN adds o_checksum, the 16-bit running sum of emitted weights.
module weight_word_unpacker
  import weight_word_unpacker_pkg::*;
#(
  parameter  int BW      = 8,
  parameter  int SIZE    = W_SIZE,
  parameter  int FIFO_AW = 2,
  localparam int WPW     = 32 / BW,
  localparam int CW      = clog2(SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 global_rst_n,
  input  logic                 user_reset,
  input  logic                 ce,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  output logic signed [BW-1:0] o_data,
  output logic                 o_we,
  output logic [CW-1:0]        o_cnt,
  output logic                 o_done,
  output logic                 o_overflow
`ifdef WUNPACK_CHECKSUM_EN
  ,
  output logic [15:0]          o_checksum
`endif
);

  localparam int LW = clog2(WPW) + 1;
  localparam logic [CW-1:0] SIZE_C     = CW'(SIZE);
  localparam logic [CW-1:0] LAST_ISSUE = CW'(SIZE - 1);

  unpack_state_e state, state_nxt;
  logic [31:0]   shreg, shreg_nxt;
  logic [LW-1:0] lanes_left, lanes_left_nxt;
  logic [31:0]   fifo_rdata;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic          emit;
  logic [BW-1:0] emit_data;
  logic [CW-1:0] issued;

  assign s_ready   = !fifo_full || (state == ST_DONE);
  assign fifo_push = s_valid && s_ready && (state != ST_DONE);
  assign o_done    = (o_cnt == SIZE_C);
  // o_cnt lags emission by one cycle; the pending o_we completes the issued count.
  assign issued    = o_cnt + CW'(o_we);

  sync_word_fifo #(.DW(32), .AW(FIFO_AW)) u_fifo (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .clr          (user_reset),
    .push         (fifo_push),
    .wdata        (s_data),
    .pop          (fifo_pop),
    .rdata        (fifo_rdata),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  always_comb begin
    state_nxt      = state;
    shreg_nxt      = shreg;
    lanes_left_nxt = lanes_left;
    fifo_pop       = 1'b0;
    emit           = 1'b0;
    emit_data      = o_data;
    if (ce && state != ST_DONE) begin
      if (lanes_left != '0) begin
        emit           = 1'b1;
        emit_data      = shreg[BW-1:0];
        shreg_nxt      = shreg >> BW;
        lanes_left_nxt = lanes_left - 1'b1;
      end else if (!fifo_empty) begin
        fifo_pop       = 1'b1;
        emit           = 1'b1;
        emit_data      = fifo_rdata[BW-1:0];
        shreg_nxt      = fifo_rdata >> BW;
        lanes_left_nxt = LW'(WPW - 1);
      end
      // Reaching SIZE drops whatever lanes of the current word remain.
      if (emit && issued == LAST_ISSUE) begin
        state_nxt      = ST_DONE;
        lanes_left_nxt = '0;
      end else if (emit) begin
        state_nxt = ST_EMIT;
      end else begin
        state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      lanes_left <= '0;
      o_data     <= '0;
      o_we       <= 1'b0;
      o_cnt      <= '0;
      o_overflow <= 1'b0;
`ifdef WUNPACK_CHECKSUM_EN
      o_checksum <= '0;
`endif
    end else if (user_reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      lanes_left <= '0;
      o_data     <= '0;
      o_we       <= 1'b0;
      o_cnt      <= '0;
      o_overflow <= 1'b0;
`ifdef WUNPACK_CHECKSUM_EN
      o_checksum <= '0;
`endif
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      lanes_left <= lanes_left_nxt;
      o_we       <= emit;
      if (emit) o_data <= emit_data;
      if (o_we && o_cnt != SIZE_C) o_cnt <= o_cnt + 1'b1;
      if (state == ST_DONE && s_valid) o_overflow <= 1'b1;
`ifdef WUNPACK_CHECKSUM_EN
      if (o_we && !o_done) o_checksum <= o_checksum + 16'(o_data);
`endif
    end
  end

endmodule

// File: tb/tb_weight_word_unpacker.sv
// tb/tb_weight_word_unpacker.sv - directed self-checking bench for weight_word_unpacker
module tb_weight_word_unpacker;

  localparam int BW      = 8;
  localparam int SIZE    = 3220;
  localparam int FIFO_AW = 2;
  localparam int NWORDS  = SIZE / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               global_rst_n, user_reset, ce, s_valid, s_ready;
  logic [31:0]        s_data;
  logic signed [7:0]  o_data;
  logic               o_we, o_done, o_overflow;
  logic [11:0]        o_cnt;
`ifdef WUNPACK_CHECKSUM_EN
  logic [15:0]        o_checksum;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  weight_word_unpacker #(.BW(BW), .SIZE(SIZE), .FIFO_AW(FIFO_AW)) dut (
    .clk          (clk),
    .global_rst_n (global_rst_n),
    .user_reset   (user_reset),
    .ce           (ce),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .o_data       (o_data),
    .o_we         (o_we),
    .o_cnt        (o_cnt),
    .o_done       (o_done),
    .o_overflow   (o_overflow)
`ifdef WUNPACK_CHECKSUM_EN
    ,
    .o_checksum   (o_checksum)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    global_rst_n = 1'b0;
    user_reset   = 1'b0;
    ce           = 1'b1;
    s_valid      = 1'b0;
    s_data       = '0;
    repeat (2) tick();
    global_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    global_rst_n = 1'b1;
    user_reset   = 1'b0;
    ce           = 1'b1;
    s_valid      = 1'b0;
    s_data       = '0;
    tick();
    global_rst_n = 1'b0;
    #2;
    tests_run++; if (o_we !== 1'b0) begin tests_failed++; $display("FAIL reset_we got %0b want 0", o_we); end
    tests_run++; if (o_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data got %h want 00", o_data); end
    tests_run++; if (o_cnt !== 12'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d want 0", o_cnt); end
    tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %0b want 0", o_done); end
    tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %0b want 0", o_overflow); end
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %0b want 1", s_ready); end
`ifdef WUNPACK_CHECKSUM_EN
    tests_run++; if (o_checksum !== 16'h0000) begin tests_failed++; $display("FAIL reset_checksum got %h want 0000", o_checksum); end
`endif
    tick();
    global_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [7:0] exp;
    do_reset();
    s_valid = 1'b1;
    s_data  = 32'h04030201;
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready got %0b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    tests_run++; if (o_we !== 1'b0) begin tests_failed++; $display("FAIL single_we_n1 got %0b want 0", o_we); end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = 8'(k + 1);
      tests_run++;
      if (o_we !== 1'b1 || o_data !== exp) begin
        tests_failed++;
        $display("FAIL single_lane%0d got we=%0b data=%h want we=1 data=%h", k, o_we, o_data, exp);
      end
    end
    tick();
    tests_run++; if (o_we !== 1'b0) begin tests_failed++; $display("FAIL single_we_end got %0b want 0", o_we); end
    tests_run++; if (o_cnt !== 12'd4) begin tests_failed++; $display("FAIL single_cnt got %0d want 4", o_cnt); end
    tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL single_done got %0b want 0", o_done); end
  endtask

  task automatic test_stream();
    int   stall_run, stall_max, pushed, data_err, first_bad;
    logic bad_we, got_start, done_last;
    logic [7:0] bad_data;
    stall_run = 0; stall_max = 0; pushed = 0; data_err = 0; first_bad = -1;
    bad_we = 1'b0; bad_data = '0; got_start = 1'b0; done_last = 1'b0;
    do_reset();
    fork
      begin : producer
        int   i, g;
        logic acc;
        i = 0; g = 0;
        while (i < NWORDS && g < 20000) begin
          s_valid = 1'b1;
          s_data  = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
          @(negedge clk);
          acc = s_ready;
          if (acc) stall_run = 0;
          else begin
            stall_run++;
            if (stall_run > stall_max) stall_max = stall_run;
          end
          @(posedge clk);
          #1;
          if (acc) i++;
          g++;
        end
        s_valid = 1'b0;
        pushed  = i;
      end
      begin : monitor
        int w;
        w = 0;
        @(negedge clk);
        while (o_we !== 1'b1 && w < 20) begin
          @(negedge clk);
          w++;
        end
        got_start = o_we;
        for (int j = 0; j < SIZE; j++) begin
          if (o_we !== 1'b1 || o_data !== 8'(j)) begin
            if (first_bad < 0) begin first_bad = j; bad_we = o_we; bad_data = o_data; end
            data_err++;
          end
          if (j == SIZE - 1) done_last = o_done;
          @(negedge clk);
        end
      end
    join
    tests_run++; if (got_start !== 1'b1) begin tests_failed++; $display("FAIL stream_start got %0b want 1 within 20 cycles", got_start); end
    tests_run++; if (pushed != NWORDS) begin tests_failed++; $display("FAIL stream_pushed got %0d want %0d", pushed, NWORDS); end
    tests_run++;
    if (data_err != 0) begin
      tests_failed++;
      $display("FAIL stream_data %0d bad, first at %0d got we=%0b data=%h want we=1 data=%h",
               data_err, first_bad, bad_we, bad_data, 8'(first_bad));
    end
    tests_run++; if (done_last !== 1'b0) begin tests_failed++; $display("FAIL stream_done_early got %0b want 0", done_last); end
    tests_run++; if (o_we !== 1'b0) begin tests_failed++; $display("FAIL stream_we_after got %0b want 0", o_we); end
    tests_run++; if (o_done !== 1'b1) begin tests_failed++; $display("FAIL stream_done got %0b want 1", o_done); end
    tests_run++; if (o_cnt !== 12'd3220) begin tests_failed++; $display("FAIL stream_cnt got %0d want 3220", o_cnt); end
    tests_run++; if (stall_max > 4) begin tests_failed++; $display("FAIL stream_stall got %0d want <=4", stall_max); end
    tick();
  endtask

  task automatic test_overflow();
    logic any_we;
    any_we = 1'b0;
    tests_run++; if (o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_before got %0b want 0", o_overflow); end
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL ovf_ready got %0b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (o_we !== 1'b0) any_we = 1'b1;
      tick();
    end
    tests_run++; if (any_we !== 1'b0) begin tests_failed++; $display("FAIL ovf_we got %0b want 0", any_we); end
    tests_run++; if (o_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %0b want 1", o_overflow); end
    tests_run++; if (o_cnt !== 12'd3220) begin tests_failed++; $display("FAIL ovf_cnt got %0d want 3220", o_cnt); end
  endtask

  task automatic test_ce_toggle();
    logic [7:0] got[$];
    logic saw_full, stop, prev_we;
    int   pushed, data_err, back_to_back;
    saw_full = 1'b0; stop = 1'b0; prev_we = 1'b0;
    pushed = 0; data_err = 0; back_to_back = 0;
    do_reset();
    fork
      begin : producer
        int   i, g;
        logic acc;
        i = 0; g = 0;
        while (i < 6 && g < 500) begin
          s_valid = 1'b1;
          s_data  = {8'(8'h40+4*i+3), 8'(8'h40+4*i+2), 8'(8'h40+4*i+1), 8'(8'h40+4*i)};
          @(negedge clk);
          acc = s_ready;
          if (!acc) saw_full = 1'b1;
          @(posedge clk);
          #1;
          if (acc) i++;
          g++;
        end
        s_valid = 1'b0;
        pushed  = i;
      end
      begin : toggler
        while (!stop) begin
          ce = ~ce;
          @(posedge clk);
          #1;
        end
        ce = 1'b1;
      end
      begin : monitor
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (o_we === 1'b1) got.push_back(o_data);
          if (o_we === 1'b1 && prev_we === 1'b1) back_to_back++;
          prev_we = o_we;
        end
        stop = 1'b1;
      end
    join
    tick();
    tests_run++; if (pushed != 6) begin tests_failed++; $display("FAIL ce_pushed got %0d want 6", pushed); end
    tests_run++; if (saw_full !== 1'b1) begin tests_failed++; $display("FAIL ce_fifo_full got %0b want 1", saw_full); end
    tests_run++; if (got.size() != 24) begin tests_failed++; $display("FAIL ce_count got %0d want 24", got.size()); end
    for (int j = 0; j < got.size() && j < 24; j++)
      if (got[j] !== 8'(8'h40 + j)) data_err++;
    tests_run++; if (data_err != 0) begin tests_failed++; $display("FAIL ce_order got %0d wrong bytes want 0", data_err); end
    tests_run++; if (back_to_back != 0) begin tests_failed++; $display("FAIL ce_gating got %0d adjacent o_we want 0", back_to_back); end
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL ce_drained_ready got %0b want 1", s_ready); end
    tests_run++; if (o_cnt !== 12'd24) begin tests_failed++; $display("FAIL ce_cnt got %0d want 24", o_cnt); end
  endtask

  task automatic test_user_reset();
    logic any_we;
    logic [7:0] exp;
    any_we = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = {8'(8'h13+16*k), 8'(8'h12+16*k), 8'(8'h11+16*k), 8'(8'h10+16*k)};
      tick();
    end
    s_valid = 1'b0;
    tests_run++;
    if (o_we !== 1'b1 || o_data !== 8'h12) begin
      tests_failed++;
      $display("FAIL ureset_lane2 got we=%0b data=%h want we=1 data=12", o_we, o_data);
    end
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    tests_run++; if (o_cnt !== 12'd0) begin tests_failed++; $display("FAIL ureset_cnt got %0d want 0", o_cnt); end
    tests_run++; if (o_we !== 1'b0) begin tests_failed++; $display("FAIL ureset_we got %0b want 0", o_we); end
    tests_run++; if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL ureset_ready got %0b want 1", s_ready); end
    for (int k = 0; k < 4; k++) begin
      if (o_we !== 1'b0) any_we = 1'b1;
      tick();
    end
    tests_run++; if (any_we !== 1'b0) begin tests_failed++; $display("FAIL ureset_fifo_empty got we=%0b want 0", any_we); end
    s_valid = 1'b1;
    s_data  = 32'hA4A3A2A1;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp = 8'(8'hA1 + k);
      tests_run++;
      if (o_we !== 1'b1 || o_data !== exp) begin
        tests_failed++;
        $display("FAIL ureset_reload_lane%0d got we=%0b data=%h want we=1 data=%h", k, o_we, o_data, exp);
      end
    end
    tick();
    tests_run++; if (o_cnt !== 12'd4) begin tests_failed++; $display("FAIL ureset_reload_cnt got %0d want 4", o_cnt); end
  endtask

`ifdef WUNPACK_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    s_valid = 1'b1;
    s_data  = 32'h807FFF01;
    tick();
    s_valid = 1'b0;
    repeat (8) tick();
    tests_run++; if (o_checksum !== 16'hFFFF) begin tests_failed++; $display("FAIL checksum got %h want ffff", o_checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_overflow();
    test_ce_toggle();
    test_user_reset();
`ifdef WUNPACK_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
